pq_sort_core: RTL and testbench

- 16-entry shift-register priority queue of 8-bit keys; keeps entries sorted ascending, so the minimum is always in slot 0.
- Sits directly upstream of the 8-bit output register stage: min_key drives that register's d input.
- Accepts push, pop and combined push+pop (replace), one operation per clock.
- Reports occupancy and flags, plus one-cycle error pulses for overflow and underflow.

---
 rtl/pq_pkg.sv | 16 +
 rtl/pq_cell.sv | 66 ++++++
 rtl/pq_sort_core.sv | 116 +++++++++++
 tb/tb_pq_sort_core.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pq_pkg.sv
// Shared types and defaults for the sorted shift-register priority queue.
package pq_pkg;
  localparam int KEY_W_DEF = 8;
  localparam int DEPTH_DEF = 16;

  typedef logic [KEY_W_DEF-1:0] key_t;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE
  } pq_op_e;

  localparam key_t KEY_EMPTY = '1;
endpackage

// File: rtl/pq_cell.sv
// One slot of the sorted queue: picks its next key from its left/right
// neighbours, the new key, or itself, based on the decoded operation.
module pq_cell
  import pq_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF,
  parameter bit FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] left_key,
  input  logic             left_vld,
  input  logic [KEY_W-1:0] right_key,
  input  logic             right_vld,
  input  logic [KEY_W-1:0] new_key,
  input  pq_op_e           op,
  input  logic             left_gt,
  output logic [KEY_W-1:0] key,
  output logic             vld,
  output logic             gt
);
  logic right_gt;

  // Empty slots count as "greater" so the insertion point lands on the first
  // empty slot; strict compare keeps equal keys in arrival order.
  assign gt       = !vld || (key > new_key);
  assign right_gt = !right_vld || (right_key > new_key);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key <= '1;
      vld <= 1'b0;
    end else begin
      case (op)
        OP_PUSH: begin
          if (left_gt) begin
            key <= left_key;
            vld <= left_vld;
          end else if (gt) begin
            key <= new_key;
            vld <= 1'b1;
          end
        end
        OP_POP: begin
          key <= right_key;
          vld <= right_vld;
        end
        OP_REPLACE: begin
          // Slot 0 is dropped: the remaining entries are seen one slot to the
          // right, so the insertion test uses the right neighbour's flag.
          if (!right_gt) begin
            key <= right_key;
            vld <= right_vld;
          end else if (FIRST || !gt) begin
            key <= new_key;
            vld <= 1'b1;
          end
        end
        default: begin
          key <= key;
          vld <= vld;
        end
      endcase
    end
  end
endmodule

// File: rtl/pq_sort_core.sv
// Sorted shift-register priority queue: minimum always in slot 0, one
// push/pop/replace per clock, occupancy flags and error pulses.
module pq_sort_core
  import pq_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [KEY_W-1:0] push_key,
  input  logic             pop,
  output logic [KEY_W-1:0] min_key,
  output logic             min_valid,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);
  logic [KEY_W-1:0] slot_key [DEPTH];
  logic [DEPTH-1:0] slot_vld;
  logic [DEPTH-1:0] slot_gt;
  logic [CNT_W-1:0] count_reg;
  logic             overflow_reg;
  logic             underflow_reg;
  logic             is_full;
  logic             is_empty;
  pq_op_e           op;

  assign is_full  = (count_reg == CNT_W'(DEPTH));
  assign is_empty = (count_reg == '0);

  // Push+pop on an empty queue degrades to a plain push.
  always_comb begin
    op = OP_IDLE;
    if (push && pop && !is_empty)
      op = OP_REPLACE;
    else if (push && !is_full)
      op = OP_PUSH;
    else if (pop && !is_empty)
      op = OP_POP;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      overflow_reg  <= push && !pop && is_full;
      underflow_reg <= pop && is_empty;
      case (op)
        OP_PUSH: count_reg <= count_reg + 1'b1;
        OP_POP:  count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
      logic [KEY_W-1:0] l_key;
      logic             l_vld;
      logic             l_gt;
      logic [KEY_W-1:0] r_key;
      logic             r_vld;

      if (gi == 0) begin : g_left_edge
        assign l_key = '1;
        assign l_vld = 1'b0;
        assign l_gt  = 1'b0;
      end else begin : g_left_link
        assign l_key = slot_key[gi-1];
        assign l_vld = slot_vld[gi-1];
        assign l_gt  = slot_gt[gi-1];
      end

      if (gi == DEPTH - 1) begin : g_right_edge
        assign r_key = '1;
        assign r_vld = 1'b0;
      end else begin : g_right_link
        assign r_key = slot_key[gi+1];
        assign r_vld = slot_vld[gi+1];
      end

      pq_cell #(
        .KEY_W (KEY_W),
        .FIRST (gi == 0)
      ) u_cell (
        .clk       (clk),
        .rst       (rst),
        .left_key  (l_key),
        .left_vld  (l_vld),
        .right_key (r_key),
        .right_vld (r_vld),
        .new_key   (push_key),
        .op        (op),
        .left_gt   (l_gt),
        .key       (slot_key[gi]),
        .vld       (slot_vld[gi]),
        .gt        (slot_gt[gi])
      );
    end
  endgenerate

  assign min_key   = slot_vld[0] ? slot_key[0] : '0;
  assign min_valid = slot_vld[0];
  assign count     = count_reg;
  assign full      = is_full;
  assign empty     = is_empty;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
endmodule

// File: tb/tb_pq_sort_core.sv
// Self-checking bench for pq_sort_core: vector table, hand sequences and a
// randomised phase checked against a sorted-list reference model.
module tb_pq_sort_core;
  import pq_pkg::*;

  localparam int KW = 8;
  localparam int D  = 16;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [KW-1:0] push_key = '0;
  logic [KW-1:0] min_key;
  logic          min_valid;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          underflow;

  always #5 clk = ~clk;

  pq_sort_core #(.KEY_W(KW), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_key  (push_key),
    .pop       (pop),
    .min_key   (min_key),
    .min_valid (min_valid),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  typedef struct {
    bit      p;
    bit      q;
    key_t    key;
    key_t    mk;
    bit      mv;
    int      cnt;
    bit      ovf;
    bit      unf;
  } vec_t;

  typedef struct {
    key_t mk;
    bit   mv;
    int   cnt;
    bit   ovf;
    bit   unf;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  key_t model[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(bit p, bit q, key_t k, key_t mk, bit mv, int cnt, bit ovf, bit unf);
    vec_t v;
    v.p = p; v.q = q; v.key = k; v.mk = mk; v.mv = mv; v.cnt = cnt; v.ovf = ovf; v.unf = unf;
    vecs.push_back(v);
  endfunction

  // Reference model: a plain sorted list with insert-after-equal.
  function automatic exp_t model_op(bit p, bit q, key_t k);
    exp_t e;
    int   idx;
    e.ovf = 1'b0;
    e.unf = 1'b0;
    if (p && q && model.size() > 0) begin
      void'(model.pop_front());
    end else if (q && !p) begin
      if (model.size() == 0) e.unf = 1'b1;
      else void'(model.pop_front());
    end else if (p && q) begin
      e.unf = 1'b1;
    end
    if (p && !(q && model.size() == D) && !(!q && model.size() == D)) begin
      idx = model.size();
      for (int i = 0; i < model.size(); i++) begin
        if (model[i] > k) begin
          idx = i;
          break;
        end
      end
      model.insert(idx, k);
    end else if (p) begin
      e.ovf = 1'b1;
    end
    e.cnt = model.size();
    e.mv  = (model.size() > 0);
    e.mk  = (model.size() > 0) ? model[0] : '0;
    return e;
  endfunction

  task automatic drive(input bit p, input bit q, input key_t k);
    @(negedge clk);
    push = p;
    pop = q;
    push_key = k;
  endtask

  task automatic step(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty when output expected", tag);
    end else begin
      e = sb.pop_front();
      $display("txn %s push=%0b pop=%0b key=%02h -> min=%02h v=%0b cnt=%0d ovf=%0b unf=%0b",
               tag, push, pop, push_key, min_key, min_valid, count, overflow, underflow);
      chk({tag, ".min_key"}, 32'(min_key), 32'(e.mk));
      chk({tag, ".min_valid"}, 32'(min_valid), 32'(e.mv));
      chk({tag, ".count"}, 32'(count), 32'(e.cnt));
      chk({tag, ".full"}, 32'(full), 32'(e.cnt == D));
      chk({tag, ".empty"}, 32'(empty), 32'(e.cnt == 0));
      chk({tag, ".overflow"}, 32'(overflow), 32'(e.ovf));
      chk({tag, ".underflow"}, 32'(underflow), 32'(e.unf));
    end
  endtask

  task automatic run_model(input bit p, input bit q, input key_t k, input string tag);
    drive(p, q, k);
    sb.push_back(model_op(p, q, k));
    step(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".min_key"}, 32'(min_key), 32'h0);
    chk({tag, ".min_valid"}, 32'(min_valid), 32'h0);
    chk({tag, ".count"}, 32'(count), 32'h0);
    chk({tag, ".full"}, 32'(full), 32'h0);
    chk({tag, ".empty"}, 32'(empty), 32'h1);
    chk({tag, ".overflow"}, 32'(overflow), 32'h0);
    chk({tag, ".underflow"}, 32'(underflow), 32'h0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    push = 1'b0;
    pop = 1'b0;
    rst = 1'b0;
    model.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    key_t k;
    int   r;

    // Vector table: explicit expected values from the test plan.
    add(1, 0, 8'h40, 8'h40, 1, 1, 0, 0);
    add(1, 0, 8'h10, 8'h10, 1, 2, 0, 0);
    add(1, 0, 8'h30, 8'h10, 1, 3, 0, 0);
    add(0, 1, 8'h00, 8'h30, 1, 2, 0, 0);
    add(0, 1, 8'h00, 8'h40, 1, 1, 0, 0);
    add(0, 1, 8'h00, 8'h00, 0, 0, 0, 0);
    add(0, 1, 8'h00, 8'h00, 0, 0, 0, 1);
    add(1, 1, 8'h22, 8'h22, 1, 1, 0, 1);
    add(0, 1, 8'h00, 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      k = 8'(8'hF0 - 16 * i);
      add(1, 0, k, k, 1, i + 1, 0, 0);
    end
    add(1, 0, 8'h05, 8'h00, 1, 16, 1, 0);
    add(1, 1, 8'h05, 8'h05, 1, 16, 0, 0);
    for (int j = 1; j < 16; j++) add(0, 1, 8'h00, 8'(16 * j), 1, 16 - j, 0, 0);
    add(0, 1, 8'h00, 8'h00, 0, 0, 0, 0);

    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].p, vecs[i].q, vecs[i].key);
      e.mk = vecs[i].mk; e.mv = vecs[i].mv; e.cnt = vecs[i].cnt;
      e.ovf = vecs[i].ovf; e.unf = vecs[i].unf;
      sb.push_back(e);
      step($sformatf("vec%0d", i));
    end

    // All-ones key must be kept apart from empty slots.
    reset_dut();
    run_model(1, 0, 8'hFF, "ff_push0");
    run_model(1, 0, 8'h7F, "ff_push1");
    run_model(1, 0, 8'h7F, "ff_push2");
    run_model(1, 0, 8'h00, "ff_push3");
    for (int i = 0; i < 5; i++) run_model(0, 1, 8'h00, $sformatf("ff_pop%0d", i));
    chk("ff_model_drained", 32'(model.size()), 32'h0);

    // Asynchronous reset between edges while a push is in progress.
    reset_dut();
    for (int i = 0; i < 5; i++) run_model(1, 0, 8'($urandom_range(0, 255)), $sformatf("ar_load%0d", i));
    @(negedge clk);
    push = 1'b1;
    pop = 1'b0;
    push_key = 8'h99;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model.delete();
    @(negedge clk);
    rst = 1'b1;
    push_key = 8'h55;
    sb.push_back(model_op(1, 0, 8'h55));
    step("ar_first_push");

    // Randomised mix against the reference model, small key set for ties.
    reset_dut();
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      k = ($urandom_range(0, 7) == 7) ? 8'hFF : 8'($urandom_range(0, 5) * 8'h20);
      if (i < 150) run_model(r < 6, r >= 4, k, $sformatf("rnd%0d", i));
      else run_model(r < 4, r >= 3, k, $sformatf("rnd%0d", i));
    end

    @(negedge clk);
    push = 1'b0;
    pop = 1'b0;
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
